// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 2-bit-op ALU.
// Captures decoded operands and control. Supports hold (stall), bubble
// insertion (flush) and automatic load-use bubbles. Drives forwarded
// ALU operands and the store data.
// Optional feature macro: ID_EX_FWD_EN enables the EX/MEM and MEM/WB
// forwarding muxes. Without it, operands come straight from the registers
// and the hazard check covers every register writer.
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [4:0]   in_rs,
    input  logic [4:0]   in_rt,
    input  logic [4:0]   in_rd,
    input  logic [W-1:0] in_rs_data,
    input  logic [W-1:0] in_rt_data,
    input  logic [W-1:0] in_imm,
    input  logic         in_uses_rt,
    input  logic [1:0]   in_alu_op,
    input  logic         in_alu_src,
    input  logic         in_reg_write,
    input  logic         in_mem_read,
    input  logic         in_mem_write,
    input  logic         in_mem_to_reg,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [4:0]   ex_rs,
    output logic [4:0]   ex_rt,
    output logic [4:0]   ex_rd,
    output logic [W-1:0] ex_imm,
    output logic [1:0]   ex_alu_op,
    output logic         ex_alu_src,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         ex_mem_to_reg,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] ex_store_data,
    output logic         load_use_stall
);

    logic [W-1:0] rs_data_q;
    logic [W-1:0] rt_data_q;
    logic [W-1:0] fwd_rs;
    logic [W-1:0] fwd_rt;
    logic         hazard_writer;

    // A bubble is identical to the reset state; load-use only acts when not held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!stall && load_use_stall)) begin
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_imm        <= '0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
        end else if (!stall) begin
            ex_rs         <= in_rs;
            ex_rt         <= in_rt;
            ex_rd         <= in_rd;
            ex_imm        <= in_imm;
            ex_alu_op     <= in_alu_op;
            ex_alu_src    <= in_alu_src;
            ex_reg_write  <= in_reg_write;
            ex_mem_read   <= in_mem_read;
            ex_mem_write  <= in_mem_write;
            ex_mem_to_reg <= in_mem_to_reg;
            rs_data_q     <= in_rs_data;
            rt_data_q     <= in_rt_data;
        end
    end

`ifdef ID_EX_FWD_EN
    // Forwarding muxes: EX/MEM beats MEM/WB, register 0 is never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_rs)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_rs)
            fwd_rs = memwb_result;

        fwd_rt = rt_data_q;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_rt)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_rt)
            fwd_rt = memwb_result;
    end

    assign hazard_writer = ex_mem_read;
`else
    logic unused_fwd_inputs;

    // No forwarding: operands come straight from the stage registers.
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
    end

    // Without forwarding, any in-flight writer must stall its consumer.
    assign hazard_writer     = ex_reg_write;
    assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd, exmem_result,
                                 memwb_reg_write, memwb_rd, memwb_result};
`endif

    // Hazard request and operand selection, all combinational into the ALU.
    always_comb begin
        load_use_stall = !flush && hazard_writer && (ex_rd != 5'd0) &&
                         ((ex_rd == in_rs) || (in_uses_rt && (ex_rd == in_rt)));
        alu_a          = fwd_rs;
        alu_b          = ex_alu_src ? ex_imm : fwd_rt;
        ex_store_data  = fwd_rt;
    end

endmodule
